// File: rtl/fac_pkg.sv
// Shared constants for the factorial accelerator: register offsets,
// opdone bit positions and the controller state encoding.
package fac_pkg;

  localparam logic [2:0] OFF_START  = 3'd0;
  localparam logic [2:0] OFF_CLEAR  = 3'd1;
  localparam logic [2:0] OFF_DONE   = 3'd2;
  localparam logic [2:0] OFF_INTREN = 3'd3;
  localparam logic [2:0] OFF_OPND   = 3'd4;
  localparam logic [2:0] OFF_RESH   = 3'd5;
  localparam logic [2:0] OFF_RESL   = 3'd6;
  localparam logic [2:0] OFF_STAT   = 3'd7;

  localparam int DONE_B = 0;
  localparam int BUSY_B = 1;
  localparam int OVF_B  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    MUL  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/fac_engine_p_if.sv
// System slave bus as seen by the factorial accelerator: select, direction,
// byte address, write data and registered read data.
interface fac_engine_p_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16
) ();
  logic              s_sel;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s_dout;

  modport master (output s_sel, s_wr, s_addr, s_din, input s_dout);
  modport slave  (input s_sel, s_wr, s_addr, s_din, output s_dout);
endinterface

// File: rtl/fac_mul_seq.sv
// Radix-2 shift-add multiplier producing a RES_W+DATA_W product of a*b.
// FAC_EARLY_TERM_EN: finish a step once the remaining multiplier bits are zero.
module fac_mul_seq #(
  parameter int DATA_W = 64,
  parameter int RES_W  = 128
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    clear,
  input  logic [RES_W-1:0]        a,
  input  logic [DATA_W-1:0]       b,
  output logic                    step_done,
  output logic [RES_W+DATA_W-1:0] product
);

  localparam int PW = RES_W + DATA_W;
  localparam int CW = $clog2(DATA_W + 1);

  logic              run_reg;
  logic [CW-1:0]     cnt_reg;
  logic [PW-1:0]     mcand_reg;
  logic [DATA_W-1:0] mplier_reg;
  logic [PW-1:0]     prod_reg;

  // The start edge already folds in multiplier bit 0, so a full step is DATA_W cycles.
`ifdef FAC_EARLY_TERM_EN
  assign step_done = run_reg && (mplier_reg == '0);
`else
  assign step_done = run_reg && (cnt_reg == CW'(DATA_W));
`endif
  assign product = prod_reg;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      run_reg    <= 1'b0;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      prod_reg   <= '0;
    end else if (start) begin
      run_reg    <= 1'b1;
      cnt_reg    <= CW'(1);
      prod_reg   <= b[0] ? PW'(a) : '0;
      mcand_reg  <= PW'(a) << 1;
      mplier_reg <= b >> 1;
    end else if (run_reg) begin
      if (step_done) begin
        run_reg <= 1'b0;
      end else begin
        if (mplier_reg[0]) begin
          prod_reg <= prod_reg + mcand_reg;
        end
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fac_engine_p.sv
// Memory-mapped factorial accelerator: computes operand! with a shared
// sequential multiplier, sticky overflow flag, opclear abort and level interrupt.
module fac_engine_p
  import fac_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int RES_W  = 128,
  parameter int ADDR_W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  fac_engine_p_if.slave  bus,
  output logic           interrupt
);

  localparam int PW = RES_W + DATA_W;

  state_t            state_reg, state_next;
  logic [RES_W-1:0]  acc_reg;
  logic [DATA_W-1:0] k_reg, operand_reg, dout_reg, rd_word, k_minus1;
  logic              intr_en_reg, done_reg, busy_reg, ovf_reg, irq_reg;
  logic              mul_start, step_done;
  logic [RES_W-1:0]  mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [PW-1:0]     product;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        off;
  logic              wr_en, rd_en, start_cmd, clear_cmd, unused_addr;

  assign addr        = bus.s_addr;
  assign off         = addr[5:3];
  assign unused_addr = &{1'b0, addr};
  assign wr_en       = bus.s_sel && bus.s_wr;
  assign rd_en       = bus.s_sel && !bus.s_wr;
  assign start_cmd   = wr_en && (off == OFF_START) && bus.s_din[0];
  assign clear_cmd   = wr_en && (off == OFF_CLEAR) && bus.s_din[0];
  assign k_minus1    = k_reg - DATA_W'(1);
  assign bus.s_dout  = dout_reg;
  assign interrupt   = irq_reg;

  fac_mul_seq #(.DATA_W(DATA_W), .RES_W(RES_W)) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (mul_start),
    .clear     (clear_cmd),
    .a         (mul_a),
    .b         (mul_b),
    .step_done (step_done),
    .product   (product)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Each step is launched from the edge that retires the previous one.
  always_comb begin
    state_next = state_reg;
    mul_start  = 1'b0;
    mul_a      = RES_W'(1);
    mul_b      = operand_reg;
    case (state_reg)
      IDLE: if (start_cmd) state_next = LOAD;
      LOAD: begin
        if (operand_reg <= DATA_W'(1)) begin
          state_next = DONE;
        end else begin
          state_next = MUL;
          mul_start  = 1'b1;
        end
      end
      MUL: begin
        if (step_done) begin
          if (k_reg == DATA_W'(2)) begin
            state_next = DONE;
          end else begin
            mul_start = 1'b1;
            mul_a     = product[RES_W-1:0];
            mul_b     = k_minus1;
          end
        end
      end
      default: ;
    endcase
    if (clear_cmd) begin
      state_next = IDLE;
      mul_start  = 1'b0;
    end
  end

  always_comb begin
    rd_word = '0;
    case (off)
      OFF_DONE: begin
        rd_word[DONE_B] = done_reg;
        rd_word[BUSY_B] = busy_reg;
        rd_word[OVF_B]  = ovf_reg;
      end
      OFF_INTREN: rd_word = DATA_W'(intr_en_reg);
      OFF_OPND:   rd_word = operand_reg;
      OFF_RESH:   rd_word = acc_reg[2*DATA_W-1:DATA_W];
      OFF_RESL:   rd_word = acc_reg[DATA_W-1:0];
      OFF_STAT:   rd_word = k_reg;
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_reg     <= RES_W'(1);
      k_reg       <= '0;
      operand_reg <= '0;
      intr_en_reg <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      irq_reg     <= 1'b0;
      dout_reg    <= '0;
    end else begin
      if (clear_cmd) begin
        acc_reg  <= RES_W'(1);
        k_reg    <= '0;
        done_reg <= 1'b0;
        busy_reg <= 1'b0;
        ovf_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: if (start_cmd) busy_reg <= 1'b1;
          LOAD: begin
            acc_reg <= RES_W'(1);
            k_reg   <= operand_reg;
            if (operand_reg <= DATA_W'(1)) begin
              busy_reg <= 1'b0;
              done_reg <= 1'b1;
            end
          end
          MUL: begin
            if (step_done) begin
              // Keep the truncated value; overflow stays latched until opclear.
              acc_reg <= product[RES_W-1:0];
              k_reg   <= k_minus1;
              if (product[PW-1:RES_W] != '0) ovf_reg <= 1'b1;
              if (k_reg == DATA_W'(2)) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
      if (wr_en && (off == OFF_OPND) && !busy_reg) operand_reg <= bus.s_din;
      if (wr_en && (off == OFF_INTREN)) intr_en_reg <= bus.s_din[0];
      if (rd_en) dout_reg <= rd_word;
      irq_reg <= done_reg && intr_en_reg;
    end
  end

endmodule

// File: tb/tb_fac_engine_p.sv
// Self-checking bench for fac_engine_p: reads feed a scoreboard queue that a
// separate monitor drains; expected values come from a wide factorial model.
module tb_fac_engine_p;

  localparam int DATA_W = 64;
  localparam int RES_W  = 128;
  localparam int ADDR_W = 16;

  typedef struct {
    logic [DATA_W-1:0] exp;
    string             nm;
  } exp_t;

  logic clk;
  logic reset_n;
  logic interrupt;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  fac_engine_p_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fac_engine_p #(.DATA_W(DATA_W), .RES_W(RES_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .interrupt (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] fact(input int n);
    logic [511:0] r;
    r = 512'd1;
    for (int i = 2; i <= n; i++) r = r * 512'(i);
    return r;
  endfunction

  // Cycles from the opstart edge until the interrupt is first seen high.
  function automatic int exp_cycles(input int n);
    int lat;
    lat = 1;
    for (int k = n; k >= 2; k--) begin
`ifdef FAC_EARLY_TERM_EN
      lat += $clog2(k + 1);
`else
      lat += DATA_W;
`endif
    end
    return lat + 1;
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end else begin
      $display("CHECK %s value=%h", nm, act);
    end
  endtask

  task automatic wr(input int off, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bus.s_sel = 1'b1; bus.s_wr = 1'b1; bus.s_addr = ADDR_W'(off << 3); bus.s_din = d;
    @(negedge clk);
    bus.s_sel = 1'b0; bus.s_wr = 1'b0;
  endtask

  task automatic rd(input int off, input logic [DATA_W-1:0] exp, input string nm);
    exp_t e;
    @(negedge clk);
    bus.s_sel = 1'b1; bus.s_wr = 1'b0; bus.s_addr = ADDR_W'(off << 3);
    e.exp = exp; e.nm = nm;
    sb_q.push_back(e);
    @(negedge clk);
    bus.s_sel = 1'b0;
  endtask

  // Monitor: every read committed at an edge is compared one step later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus.s_sel && !bus.s_wr && reset_n) begin
        #1;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected actual=%h required=none", bus.s_dout);
        end else begin
          e = sb_q.pop_front();
          if (bus.s_dout !== e.exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", e.nm, bus.s_dout, e.exp);
          end else begin
            $display("READ %s value=%h", e.nm, bus.s_dout);
          end
        end
      end
    end
  end

  task automatic start_and_time(input int n);
    int cyc;
    @(negedge clk);
    bus.s_sel = 1'b1; bus.s_wr = 1'b1; bus.s_addr = ADDR_W'(0); bus.s_din = 64'd1;
    @(posedge clk);
    #1;
    bus.s_sel = 1'b0; bus.s_wr = 1'b0;
    cyc = 0;
    while (cyc < 8000 && !interrupt) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk($sformatf("latency_n%0d", n), DATA_W'(cyc), DATA_W'(exp_cycles(n)));
  endtask

  task automatic run_op(input int n);
    logic [511:0]      full;
    logic [RES_W-1:0]  res;
    logic              ovf;
    logic [DATA_W-1:0] opd, stat;
    full = fact(n);
    res  = full[RES_W-1:0];
    ovf  = |full[511:RES_W];
    opd  = {61'd0, ovf, 1'b0, 1'b1};
    stat = (n <= 1) ? DATA_W'(n) : DATA_W'(1);
    wr(4, DATA_W'(n));
    rd(4, DATA_W'(n), "operand");
    start_and_time(n);
    rd(2, opd, "opdone_done");
    rd(6, res[63:0], "result_l");
    rd(5, res[127:64], "result_h");
    rd(7, stat, "status_done");
    // Ignored pokes while DONE: opstart, read-only write, unselected write.
    wr(0, 64'd1);
    wr(6, 64'hDEAD_BEEF);
    @(negedge clk);
    bus.s_sel = 1'b0; bus.s_wr = 1'b1; bus.s_addr = ADDR_W'(4 << 3); bus.s_din = 64'd99;
    @(negedge clk);
    bus.s_wr = 1'b0;
    rd(2, opd, "opdone_hold");
    rd(6, res[63:0], "result_l_hold");
    rd(4, DATA_W'(n), "operand_hold");
    chk("irq_done", DATA_W'(interrupt), 64'd1);
    wr(1, 64'd1);
    @(posedge clk);
    #1;
    chk("irq_cleared", DATA_W'(interrupt), 64'd0);
    rd(2, 64'd0, "opdone_cleared");
    rd(6, 64'd1, "result_l_cleared");
  endtask

  initial begin
    int n;
    int guard;
    reset_n = 1'b0;
    bus.s_sel = 1'b0; bus.s_wr = 1'b0; bus.s_addr = '0; bus.s_din = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_dout", bus.s_dout, 64'd0);
    chk("rst_irq", DATA_W'(interrupt), 64'd0);
    rd(2, 64'd0, "rst_opdone");
    rd(3, 64'd0, "rst_intren");
    rd(4, 64'd0, "rst_operand");
    rd(6, 64'd1, "rst_result_l");
    rd(5, 64'd0, "rst_result_h");
    rd(7, 64'd0, "rst_status");
    rd(0, 64'd0, "wo_opstart");
    rd(1, 64'd0, "wo_opclear");
    wr(3, 64'd1);
    rd(3, 64'd1, "intren");

    run_op(5);
    run_op(0);
    run_op(1);
    run_op(21);
    run_op(34);
    run_op(35);
    run_op(3);
    for (int i = 0; i < 6; i++) begin
      n = int'($urandom_range(2, 30));
      run_op(n);
    end

    // Abort mid-MUL on operand 10.
    wr(4, 64'd10);
    wr(0, 64'd1);
    repeat (60) @(negedge clk);
    wr(4, 64'd3);
    rd(4, 64'd10, "operand_busy");
    rd(2, 64'd2, "opdone_busy");
    wr(1, 64'd1);
    rd(2, 64'd0, "opdone_abort");
    rd(6, 64'd1, "result_l_abort");
    rd(7, 64'd0, "status_abort");
    rd(4, 64'd10, "operand_kept");
    repeat (800) @(negedge clk);
    rd(2, 64'd0, "opdone_after_abort");
    chk("irq_after_abort", DATA_W'(interrupt), 64'd0);

    // Reset mid-MUL on operand 10.
    wr(0, 64'd1);
    repeat (100) @(negedge clk);
    rd(4, 64'd10, "operand_pre_reset");
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_dout", bus.s_dout, 64'd0);
    chk("midrst_irq", DATA_W'(interrupt), 64'd0);
    rd(2, 64'd0, "midrst_opdone");
    rd(3, 64'd0, "midrst_intren");
    rd(4, 64'd0, "midrst_operand");
    rd(6, 64'd1, "midrst_result_l");
    rd(5, 64'd0, "midrst_result_h");
    rd(7, 64'd0, "midrst_status");
    wr(3, 64'd1);
    run_op(4);

    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fac_engine_p.md
Name: fac_engine_p

Overview:
- Parametrised, memory-mapped factorial accelerator; successor to the fixed 64-bit factorial slave.
- Computes operand! with a shared sequential shift-add multiplier. Result width, operand width and bus width are configurable.
- Adds sticky overflow detection, abort via opclear, and a level interrupt.
- Sits on the system slave bus next to other bus-mapped peripherals.

Parameters:
- DATA_W, 64, bus/operand/register width; also the multiplier iteration count.
- RES_W, 128, result accumulator width; must be a multiple of DATA_W and at least 2*DATA_W.
- ADDR_W, 16, slave address width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  reset, synchronous, active-low
- s_sel  in  1  slave select for the current bus cycle
- s_wr  in  1  1 = write, 0 = read (qualified by s_sel)
- s_addr  in  ADDR_W  byte address; s_addr[5:3] is the register offset
- s_din  in  DATA_W  write data
- s_dout  out  DATA_W  registered read data
- interrupt  out  1  level interrupt: done & intrEn[0]

Behaviour:
- Register map (offset = s_addr[5:3]):
  - 0 opstart (W): bit0 starts an operation.
  - 1 opclear (W): bit0 aborts/clears.
  - 2 opdone (R): bit0 done, bit1 busy, bit2 overflow.
  - 3 intrEn (R/W): bit0 enables the interrupt.
  - 4 operand (R/W).
  - 5 result_h (R): result[2*DATA_W-1:DATA_W].
  - 6 result_l (R): result[DATA_W-1:0].
  - 7 status (R): iteration counter k.
- Reads: s_dout is updated on the edge after s_sel & !s_wr and holds its value otherwise. Reads of write-only offsets return 0.
- Reset (reset_n=0 at an edge):
  - State IDLE, acc=1, k=0, operand=0, intrEn=0.
  - done, busy and overflow cleared; interrupt=0; s_dout=0.
  - Reset mid-operation aborts immediately; the same values apply.
- FSM states: IDLE, LOAD, MUL, DONE.
  - IDLE: an opstart write with bit0=1 moves to LOAD on the next edge.
  - LOAD (1 cycle): acc=1, k=operand, busy=1. If k<=1, go to DONE (0!=1!=1). Otherwise go to MUL.
  - MUL: the fac_mul_seq step computes acc*k. When step_done: acc=product[RES_W-1:0], k=k-1. If k-1==1, go to DONE; otherwise start the next step.
  - DONE: busy=0, done=1. Holds until opclear. A new opstart in DONE is ignored until opclear.
- Latency for n>=2: 1 + (n-1)*DATA_W cycles from LOAD entry to DONE entry. Each step takes exactly DATA_W cycles, radix-2.
- Arithmetic:
  - The step uses an RES_W+DATA_W internal product.
  - If product[RES_W+DATA_W-1:RES_W] != 0, overflow=1 (sticky until opclear). The truncated result continues to be computed.
- Interrupt: the registered value done & intrEn[0]. It updates the cycle after either term changes.
- opclear bit0 write, from any state: on the next edge go to IDLE, acc=1, k=0, clear done/busy/overflow. This aborts an in-flight step. operand and intrEn are kept.
- Write to operand while busy: ignored. opstart while busy: ignored.
- s_sel=0: no register effect. Writes to read-only offsets: ignored.
- If opstart and opclear commit in the same cycle, opclear wins. This is only possible via back-to-back pipelined writes.

Optional Feature:
- FAC_EARLY_TERM_EN
  - Defined: each multiply step ends as soon as the remaining multiplier bits are all zero. Latency per step is floor(log2 k)+1 cycles; the total latency becomes data-dependent.
  - Undefined: fixed DATA_W cycles per step, with latency exactly as specified above.
  - Results and the overflow flag are identical either way.

Decomposition:
- Package fac_pkg:
  - Offset localparams: OFF_START=0, OFF_CLEAR=1, OFF_DONE=2, OFF_INTREN=3, OFF_OPND=4, OFF_RESH=5, OFF_RESL=6, OFF_STAT=7.
  - opdone bit indices: DONE_B=0, BUSY_B=1, OVF_B=2.
  - FSM state typedef/encoding: IDLE=2'b00, LOAD=2'b01, MUL=2'b10, DONE=2'b11.
- Sub-module fac_mul_seq: sequential shift-add multiplier.
  - Inputs: start, clear, a[RES_W], b[DATA_W].
  - Outputs: step_done (1-cycle pulse), product[RES_W+DATA_W].

Test Plan:
- operand=5, opstart=1 -> DONE after 257 cycles; result_l=0x78, result_h=0, opdone=3'b001.
- operand=0, then operand=1 -> each reaches DONE one cycle after LOAD with result_l=1 and opdone=3'b001.
- operand=21 -> result_h=0x2, result_l=0xC5077D36B8C40000, overflow=0.
- operand=34 -> overflow=0 (34! fits in 128 bits); operand=35 -> overflow=1 and done=1.
- intrEn=1, operand=3 -> interrupt rises one cycle after done; opclear -> interrupt=0 and opdone=0.
- Mid-MUL checks on operand=10:
  - opclear -> IDLE next edge, result_l=1.
  - Reset mid-MUL -> all registers and outputs return to reset values.
  - Operand write during busy -> ignored; operand still reads back 10.
